// File: rtl/display_scan_mux.sv
// Multiplexed four-digit 7-segment scanner with per-slot anti-ghost blanking.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading-zero digits.
module display_scan_mux #(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [3:0]  nib,
    output logic [3:0]  an_n,
    output logic        dp_n,
    output logic [1:0]  digit_idx,
    output logic        frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BEND = CW'(BLANK_CYCLES);

    typedef enum logic {
        ST_BLANK,
        ST_ON
    } state_t;

    state_t      state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]  idx_nx;
    logic        wrap, boundary, xfer;

    logic [15:0] active, act_nx, pending, pend_nx;
    logic [3:0]  dp_act, dpa_nx, dp_pend, dpp_nx;
    logic        pend_flag, flag_nx;

    logic [3:0]  nib_nx, an_nx, digit_on, lz_mask;
    logic        dp_nx;

    // Slot counter, digit index and FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            digit_idx <= 2'd0;
            state     <= ST_BLANK;
        end else begin
            cnt       <= cnt_nx;
            digit_idx <= idx_nx;
            state     <= state_nx;
        end
    end

    // Next slot position; BLANK covers the first BLANK_CYCLES counts
    always_comb begin
        cnt_nx   = cnt;
        idx_nx   = digit_idx;
        wrap     = (cnt == LAST);
        boundary = en && wrap && (digit_idx == 2'd3);
        if (!en) begin
            cnt_nx = '0;
            idx_nx = 2'd0;
        end else if (wrap) begin
            cnt_nx = '0;
            idx_nx = digit_idx + 2'd1;
        end else begin
            cnt_nx = cnt + 1'b1;
        end
        state_nx = (en && cnt_nx >= BEND) ? ST_ON : ST_BLANK;
    end

    // Pending/active registers; active only changes at a frame edge or while dark
    always_comb begin
        act_nx  = active;
        dpa_nx  = dp_act;
        pend_nx = pending;
        dpp_nx  = dp_pend;
        flag_nx = pend_flag;
        xfer    = boundary || !en;
        if (load) begin
            pend_nx = value;
            dpp_nx  = dp_in;
        end
        if (xfer) begin
            if (load) begin
                act_nx  = value;
                dpa_nx  = dp_in;
                flag_nx = 1'b0;
            end else if (pend_flag) begin
                act_nx  = pending;
                dpa_nx  = dp_pend;
                flag_nx = 1'b0;
            end
        end else if (load) begin
            flag_nx = 1'b1;
        end
    end

    // Data register update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= '0;
            dp_act    <= '0;
            pending   <= '0;
            dp_pend   <= '0;
            pend_flag <= 1'b0;
        end else begin
            active    <= act_nx;
            dp_act    <= dpa_nx;
            pending   <= pend_nx;
            dp_pend   <= dpp_nx;
            pend_flag <= flag_nx;
        end
    end

    // Output values computed from next state so registers align with digit_idx
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        lz_mask[0] = 1'b0;
        lz_mask[1] = (act_nx[15:4] == 12'h0) && !dpa_nx[1];
        lz_mask[2] = (act_nx[15:8] == 8'h0) && !dpa_nx[2];
        lz_mask[3] = (act_nx[15:12] == 4'h0) && !dpa_nx[3];
`else
        lz_mask = 4'h0;
`endif
        nib_nx   = act_nx[{idx_nx, 2'b00} +: 4];
        digit_on = (4'b0001 << idx_nx) & ~lz_mask;
        an_nx    = 4'hF;
        dp_nx    = 1'b1;
        if (state_nx == ST_ON) begin
            an_nx = ~digit_on;
            dp_nx = ~dpa_nx[idx_nx];
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib        <= 4'h0;
            an_n       <= 4'hF;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            nib        <= nib_nx;
            an_n       <= an_nx;
            dp_n       <= dp_nx;
            frame_done <= boundary;
        end
    end

endmodule
